bp_lce_req_mshr: RTL and testbench

Multi-outstanding successor to the single-miss front-end LCE request engine. Tracks up to `num_mshr_p` cache requests (cached load/store misses, uncached loads/stores) in independent slots. Issues LCE→CCE requests and coherence acks through round-robin arbitration. Sits between the I/D cache miss path and the LCE→CCE request/response networks, beside the LCE command engine.

---
 rtl/bp_lce_req_mshr_pkg.sv | 78 +++++++
 rtl/bp_lce_req_slot.sv | 62 ++++++
 rtl/bp_lce_req_mshr.sv | 183 ++++++++++++++++++
 tb/tb_bp_lce_req_mshr.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_lce_req_mshr_pkg.sv
// Shared types for the multi-outstanding LCE request engine.
// Covers the cache request, LCE<->CCE message formats, slot state, and the CCE mapping and arbitration helpers.
package bp_lce_req_mshr_pkg;
    localparam int paddr_width_p         = 32;
    localparam int lce_id_width_p        = 4;
    localparam int cce_id_width_p        = 4;
    localparam int lce_assoc_p           = 8;
    localparam int cce_block_width_p     = 512;
    localparam int num_cce_p             = 2;
    localparam int dword_width_p         = 64;
    localparam int way_width_lp          = $clog2(lce_assoc_p);
    localparam int block_offset_width_lp = $clog2(cce_block_width_p / 8);

    typedef enum logic [1:0] {e_miss_load, e_miss_store, e_uc_load, e_uc_store} bp_cache_req_msg_e;
    typedef enum logic [1:0] {e_size_1, e_size_2, e_size_4, e_size_8} bp_cache_req_size_e;

    typedef struct packed {
        bp_cache_req_msg_e          msg_type;
        logic [paddr_width_p-1:0]   addr;
        bp_cache_req_size_e         size;
        logic [dword_width_p-1:0]   data;
    } bp_cache_req_s;

    typedef struct packed {
        logic [way_width_lp-1:0] repl_way;
        logic                    dirty;
    } bp_cache_req_metadata_s;

    typedef enum logic [1:0] {
        e_lce_req_type_rd, e_lce_req_type_wr, e_lce_req_type_uc_rd, e_lce_req_type_uc_wr
    } bp_lce_cce_req_type_e;
    typedef enum logic {e_lce_req_excl, e_lce_req_non_excl} bp_lce_cce_req_non_excl_e;
    typedef enum logic [1:0] {
        e_lce_cce_sync_ack, e_lce_cce_inv_ack, e_lce_cce_tr_ack, e_lce_cce_coh_ack
    } bp_lce_cce_resp_type_e;

    typedef struct packed {
        logic [cce_id_width_p-1:0]  dst_id;
        logic [lce_id_width_p-1:0]  src_id;
        bp_lce_cce_req_type_e       msg_type;
        bp_lce_cce_req_non_excl_e   non_exclusive;
        logic [paddr_width_p-1:0]   addr;
        logic [way_width_lp-1:0]    lru_way_id;
        logic                       lru_dirty;
        bp_cache_req_size_e         uc_size;
        logic [dword_width_p-1:0]   data;
    } bp_lce_cce_req_s;

    typedef struct packed {
        logic [cce_id_width_p-1:0]  dst_id;
        logic [lce_id_width_p-1:0]  src_id;
        bp_lce_cce_resp_type_e      msg_type;
        logic [paddr_width_p-1:0]   addr;
    } bp_lce_cce_resp_s;

    typedef enum logic [2:0] {e_free, e_wait_md, e_send_req, e_sleep, e_send_ack} bp_lce_req_slot_state_e;

    typedef struct packed {
        bp_cache_req_s          req;
        bp_cache_req_metadata_s md;
    } bp_lce_req_slot_s;

    // CCEs are interleaved on the low block-address bits
    function automatic logic [cce_id_width_p-1:0] bp_me_addr_to_cce_id(input logic [paddr_width_p-1:0] addr);
        return cce_id_width_p'(addr[block_offset_width_lp +: $clog2(num_cce_p)]);
    endfunction

    function automatic logic [2:0] rr_pick(input logic [7:0] reqs, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic [2:0] idx;
        pick = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            idx = 3'((int'(ptr) + i) % n);
            if (reqs[idx]) pick = idx;
        end
        return pick;
    endfunction
endpackage

// File: rtl/bp_lce_req_slot.sv
// One MSHR slot: FSM from allocation through request, completion wait and coherence ack.
// Events arrive pre-decoded for this slot; anything outside e_sleep is dropped.
module bp_lce_req_slot
    import bp_lce_req_mshr_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   alloc,
    input  bp_cache_req_s          req,
    input  logic                   md_v,
    input  bp_cache_req_metadata_s md,
    input  logic                   req_done,
    input  logic                   ack_done,
    input  logic                   data_v,
    input  logic                   set_tag_v,
    input  logic                   wakeup_v,
    input  logic                   uc_done_v,
    output bp_lce_req_slot_state_e state,
    output bp_lce_req_slot_s       rec
);
    logic data_seen, set_tag_seen, data_now, set_tag_now, uncached;

    assign data_now    = data_seen | data_v;
    assign set_tag_now = set_tag_seen | set_tag_v;
    assign uncached    = (rec.req.msg_type == e_uc_load) || (rec.req.msg_type == e_uc_store);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state        <= e_free;
            rec          <= '0;
            data_seen    <= 1'b0;
            set_tag_seen <= 1'b0;
        end else begin
            case (state)
                e_free: if (alloc) begin
                    state        <= e_wait_md;
                    rec.req      <= req;
                    rec.md       <= '0;
                    data_seen    <= 1'b0;
                    set_tag_seen <= 1'b0;
                end
                e_wait_md: if (md_v) begin
                    rec.md <= md;
                    state  <= e_send_req;
                end
                e_send_req: if (req_done) state <= e_sleep;
                e_sleep: begin
                    if (uncached) begin
                        if (uc_done_v) state <= e_free;
                    end else if (wakeup_v || (data_now && set_tag_now)) begin
                        state <= e_send_ack;
                    end else begin
                        data_seen    <= data_now;
                        set_tag_seen <= set_tag_now;
                    end
                end
                e_send_ack: if (ack_done) state <= e_free;
                default: state <= e_free;
            endcase
        end
    end
endmodule

// File: rtl/bp_lce_req_mshr.sv
// Multi-outstanding LCE request engine: lowest-free allocation, block hazard check, RR request/ack issue.
// Request valid two cycles after accept at the earliest; grants hold across ready/yumi stalls.
module bp_lce_req_mshr
    import bp_lce_req_mshr_pkg::*;
#(
    parameter int num_mshr_p          = 2,
    parameter int timeout_max_limit_p = 4,
    localparam int slot_id_width_lp   = (num_mshr_p > 1) ? $clog2(num_mshr_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [lce_id_width_p-1:0]             lce_id_i,
    input  bp_cache_req_s                         cache_req_i,
    input  logic                                  cache_req_v_i,
    output logic                                  cache_req_ready_o,
    input  bp_cache_req_metadata_s                cache_req_metadata_i,
    input  logic                                  cache_req_metadata_v_i,
    output logic [num_mshr_p*paddr_width_p-1:0]   slot_addr_o,
    output logic [num_mshr_p-1:0]                 slot_v_o,
    input  logic                                  data_received_v_i,
    input  logic                                  set_tag_received_v_i,
    input  logic                                  set_tag_wakeup_v_i,
    input  logic                                  uc_done_v_i,
    input  logic [slot_id_width_lp-1:0]           event_slot_i,
    input  logic                                  coherence_blocked_i,
    input  logic                                  cmd_ready_i,
    output bp_lce_cce_req_s                       lce_req_o,
    output logic                                  lce_req_v_o,
    input  logic                                  lce_req_ready_i,
    output bp_lce_cce_resp_s                      lce_resp_o,
    output logic                                  lce_resp_v_o,
    input  logic                                  lce_resp_yumi_i,
    output logic                                  busy_o
);
    localparam int cnt_w = $clog2(timeout_max_limit_p + 1);

    bp_lce_req_slot_state_e    state [num_mshr_p];
    bp_lce_req_slot_s          rec   [num_mshr_p];
    bp_lce_req_slot_s          req_sel, ack_sel;
    logic [7:0]                req_vec, ack_vec;
    logic                      any_free, any_wait_md, hazard, timeout, accept, req_cached;
    logic [2:0]                alloc_id, req_ptr, ack_ptr, req_grant, ack_grant, req_lock_id, ack_lock_id, event_id;
    logic                      req_lock, ack_lock;
    logic [cnt_w-1:0]          blocked_cnt;
    logic [paddr_width_p-1:0]  req_addr;

    assign event_id = 3'(event_slot_i);
    assign timeout  = blocked_cnt == cnt_w'(timeout_max_limit_p);

    always_comb begin
        any_free    = 1'b0;
        any_wait_md = 1'b0;
        hazard      = 1'b0;
        alloc_id    = '0;
        req_vec     = '0;
        ack_vec     = '0;
        slot_v_o    = '0;
        slot_addr_o = '0;
        // Descending walk so the lowest free index wins
        for (int i = num_mshr_p - 1; i >= 0; i--) begin
            if (state[i] == e_free) begin
                any_free = 1'b1;
                alloc_id = 3'(i);
            end else begin
                slot_v_o[i] = 1'b1;
                slot_addr_o[i*paddr_width_p +: paddr_width_p] = rec[i].req.addr;
                if (rec[i].req.addr[paddr_width_p-1:block_offset_width_lp]
                    == cache_req_i.addr[paddr_width_p-1:block_offset_width_lp]) hazard = 1'b1;
            end
            if (state[i] == e_wait_md)  any_wait_md = 1'b1;
            if (state[i] == e_send_req) req_vec[i]  = 1'b1;
            if (state[i] == e_send_ack) ack_vec[i]  = 1'b1;
        end
    end

    assign cache_req_ready_o = cmd_ready_i & ~timeout & any_free & ~any_wait_md & ~hazard;
    assign accept            = cache_req_v_i & cache_req_ready_o;
    assign busy_o            = |slot_v_o;
    assign lce_req_v_o       = |req_vec;
    assign lce_resp_v_o      = |ack_vec;
    assign req_grant         = req_lock ? req_lock_id : rr_pick(req_vec, req_ptr, num_mshr_p);
    assign ack_grant         = ack_lock ? ack_lock_id : rr_pick(ack_vec, ack_ptr, num_mshr_p);

    for (genvar g = 0; g < num_mshr_p; g++) begin : g_slot
        logic hit;
        assign hit = event_id == 3'(g);
        bp_lce_req_slot u_slot (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .alloc     (accept && alloc_id == 3'(g)),
            .req       (cache_req_i),
            .md_v      (cache_req_metadata_v_i),
            .md        (cache_req_metadata_i),
            .req_done  (lce_req_v_o && lce_req_ready_i && req_grant == 3'(g)),
            .ack_done  (lce_resp_v_o && lce_resp_yumi_i && ack_grant == 3'(g)),
            .data_v    (data_received_v_i && hit),
            .set_tag_v (set_tag_received_v_i && hit),
            .wakeup_v  (set_tag_wakeup_v_i && hit),
            .uc_done_v (uc_done_v_i && hit),
            .state     (state[g]),
            .rec       (rec[g])
        );
    end

    always_comb begin
        req_sel = '0;
        ack_sel = '0;
        for (int i = 0; i < num_mshr_p; i++) begin
            if (3'(i) == req_grant) req_sel = rec[i];
            if (3'(i) == ack_grant) ack_sel = rec[i];
        end
    end

    always_comb begin
        lce_req_o  = '0;
        req_addr   = req_sel.req.addr;
        req_cached = (req_sel.req.msg_type == e_miss_load) || (req_sel.req.msg_type == e_miss_store);
        if (req_cached) begin
            req_addr = {req_sel.req.addr[paddr_width_p-1:block_offset_width_lp], block_offset_width_lp'(0)};
        end else begin
            case (req_sel.req.size)
                e_size_2: req_addr[0]   = 1'b0;
                e_size_4: req_addr[1:0] = 2'b0;
                e_size_8: req_addr[2:0] = 3'b0;
                default:  req_addr      = req_sel.req.addr;
            endcase
        end
        if (lce_req_v_o) begin
            lce_req_o.dst_id = bp_me_addr_to_cce_id(req_addr);
            lce_req_o.src_id = lce_id_i;
            lce_req_o.addr   = req_addr;
            case (req_sel.req.msg_type)
                e_miss_load:  lce_req_o.msg_type = e_lce_req_type_rd;
                e_miss_store: lce_req_o.msg_type = e_lce_req_type_wr;
                e_uc_load:    lce_req_o.msg_type = e_lce_req_type_uc_rd;
                default:      lce_req_o.msg_type = e_lce_req_type_uc_wr;
            endcase
            if (req_cached) begin
                lce_req_o.non_exclusive = (req_sel.req.msg_type == e_miss_load) ? e_lce_req_non_excl : e_lce_req_excl;
                lce_req_o.lru_way_id    = req_sel.md.repl_way;
                lce_req_o.lru_dirty     = req_sel.md.dirty;
            end else begin
                lce_req_o.uc_size = req_sel.req.size;
                if (req_sel.req.msg_type == e_uc_store) lce_req_o.data = req_sel.req.data;
            end
        end
    end

    always_comb begin
        lce_resp_o = '0;
        if (lce_resp_v_o) begin
            lce_resp_o.dst_id   = bp_me_addr_to_cce_id(ack_sel.req.addr);
            lce_resp_o.src_id   = lce_id_i;
            lce_resp_o.msg_type = e_lce_cce_coh_ack;
            lce_resp_o.addr     = ack_sel.req.addr;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_ptr     <= '0;
            ack_ptr     <= '0;
            req_lock    <= 1'b0;
            ack_lock    <= 1'b0;
            req_lock_id <= '0;
            ack_lock_id <= '0;
            blocked_cnt <= '0;
        end else begin
            req_lock    <= lce_req_v_o & ~lce_req_ready_i;
            ack_lock    <= lce_resp_v_o & ~lce_resp_yumi_i;
            req_lock_id <= req_grant;
            ack_lock_id <= ack_grant;
            if (lce_req_v_o && lce_req_ready_i)
                req_ptr <= (req_grant == 3'(num_mshr_p - 1)) ? 3'd0 : req_grant + 3'd1;
            if (lce_resp_v_o && lce_resp_yumi_i)
                ack_ptr <= (ack_grant == 3'(num_mshr_p - 1)) ? 3'd0 : ack_grant + 3'd1;
            if (!coherence_blocked_i)
                blocked_cnt <= '0;
            else if (!timeout)
                blocked_cnt <= blocked_cnt + cnt_w'(1);
        end
    end
endmodule

// File: tb/tb_bp_lce_req_mshr.sv
// Directed bench for bp_lce_req_mshr with two slots and hand-computed expectations.
module tb_bp_lce_req_mshr;
    import bp_lce_req_mshr_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [3:0]             lce_id = 4'h5;
    bp_cache_req_s          cache_req = '0;
    logic                   cache_req_v = 1'b0;
    logic                   cache_req_ready;
    bp_cache_req_metadata_s md = '0;
    logic                   md_v = 1'b0;
    logic [63:0]            slot_addr;
    logic [1:0]             slot_v;
    logic                   data_v = 1'b0, set_tag_v = 1'b0, wakeup_v = 1'b0, uc_done_v = 1'b0;
    logic                   event_slot = 1'b0;
    logic                   blocked = 1'b0, cmd_ready = 1'b1;
    bp_lce_cce_req_s        lce_req;
    logic                   lce_req_v, lce_req_ready = 1'b0;
    bp_lce_cce_resp_s       lce_resp;
    logic                   lce_resp_v, lce_resp_yumi = 1'b0;
    logic                   busy;
    int                     checks = 0;
    int                     failures = 0;

    always #5 clk = ~clk;

    bp_lce_req_mshr #(.num_mshr_p(2), .timeout_max_limit_p(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
        .cache_req_i(cache_req), .cache_req_v_i(cache_req_v), .cache_req_ready_o(cache_req_ready),
        .cache_req_metadata_i(md), .cache_req_metadata_v_i(md_v),
        .slot_addr_o(slot_addr), .slot_v_o(slot_v),
        .data_received_v_i(data_v), .set_tag_received_v_i(set_tag_v),
        .set_tag_wakeup_v_i(wakeup_v), .uc_done_v_i(uc_done_v), .event_slot_i(event_slot),
        .coherence_blocked_i(blocked), .cmd_ready_i(cmd_ready),
        .lce_req_o(lce_req), .lce_req_v_o(lce_req_v), .lce_req_ready_i(lce_req_ready),
        .lce_resp_o(lce_resp), .lce_resp_v_o(lce_resp_v), .lce_resp_yumi_i(lce_resp_yumi),
        .busy_o(busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bp_cache_req_msg_e m, input logic [31:0] a,
                           input bp_cache_req_size_e s, input logic [63:0] d);
        cache_req.msg_type = m;
        cache_req.addr     = a;
        cache_req.size     = s;
        cache_req.data     = d;
    endtask

    initial begin
        // Reset state
        set_req(e_miss_load, 32'h8000_0040, e_size_8, 64'h0);
        #12;
        check("rst_req_v", lce_req_v, 0);
        check("rst_resp_v", lce_resp_v, 0);
        check("rst_busy", busy, 0);
        check("rst_slot_v", slot_v, 0);
        check("rst_slot_addr", slot_addr, 0);
        check("rst_ready_follows_cmd", cache_req_ready, 1);
        cmd_ready = 1'b0;
        #1 check("rst_ready_cmd_low", cache_req_ready, 0);
        cmd_ready = 1'b1;
        reset_n = 1'b1;
        step();

        // Single miss_load, set_tag then data, one ack
        cache_req_v = 1'b1;
        #1 check("t1_ready", cache_req_ready, 1);
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1; md = '{repl_way: 3'd3, dirty: 1'b0};
        #1 check("t1_slot_v", slot_v, 2'b01);
        check("t1_no_early_req", lce_req_v, 0);
        check("t1_wait_md_ready", cache_req_ready, 0);
        step();
        md_v = 1'b0;
        #1 check("t1_req_v", lce_req_v, 1);
        check("t1_req_type", lce_req.msg_type, e_lce_req_type_rd);
        check("t1_req_addr", lce_req.addr, 32'h8000_0040);
        check("t1_req_way", lce_req.lru_way_id, 3);
        check("t1_req_nonexcl", lce_req.non_exclusive, e_lce_req_non_excl);
        check("t1_req_dst", lce_req.dst_id, 1);
        check("t1_req_src", lce_req.src_id, 5);
        check("t1_hazard_self", cache_req_ready, 0);
        lce_req_ready = 1'b1;
        step();
        lce_req_ready = 1'b0;
        set_tag_v = 1'b1; event_slot = 1'b0;
        #1 check("t1_req_done", lce_req_v, 0);
        step();
        set_tag_v = 1'b0; data_v = 1'b1;
        #1 check("t1_no_ack_settag_only", lce_resp_v, 0);
        step();
        data_v = 1'b0;
        #1 check("t1_ack_v", lce_resp_v, 1);
        check("t1_ack_type", lce_resp.msg_type, e_lce_cce_coh_ack);
        check("t1_ack_addr", lce_resp.addr, 32'h8000_0040);
        check("t1_ack_dst", lce_resp.dst_id, 1);
        step();
        #1 check("t1_ack_held", lce_resp_v, 1);
        lce_resp_yumi = 1'b1;
        step();
        lce_resp_yumi = 1'b0;
        #1 check("t1_ack_gone", lce_resp_v, 0);
        check("t1_freed", busy, 0);

        // Timeout: four blocked cycles, ready low only on the fifth
        blocked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("to_ready_while_counting", cache_req_ready, 1);
            step();
        end
        blocked = 1'b0;
        #1 check("to_ready_at_max", cache_req_ready, 0);
        step();
        #1 check("to_ready_after_clear", cache_req_ready, 1);

        // Uncached store
        set_req(e_uc_store, 32'h0000_1004, e_size_4, 64'hDEAD_BEEF);
        cache_req_v = 1'b1;
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1; md = '0;
        step();
        md_v = 1'b0;
        #1 check("uc_req_type", lce_req.msg_type, e_lce_req_type_uc_wr);
        check("uc_req_addr", lce_req.addr, 32'h0000_1004);
        check("uc_req_size", lce_req.uc_size, e_size_4);
        check("uc_req_data", lce_req.data, 64'hDEAD_BEEF);
        check("uc_req_dst", lce_req.dst_id, 0);
        lce_req_ready = 1'b1;
        step();
        lce_req_ready = 1'b0;
        uc_done_v = 1'b1; event_slot = 1'b0;
        #1 check("uc_busy_before_done", busy, 1);
        step();
        uc_done_v = 1'b0;
        #1 check("uc_freed", busy, 0);
        check("uc_no_ack", lce_resp_v, 0);

        // Two misses under lce_req backpressure, third refused until an ack yumi
        set_req(e_miss_load, 32'h100, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1; md = '{repl_way: 3'd1, dirty: 1'b0};
        step();
        md_v = 1'b0;
        set_req(e_miss_store, 32'h200, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        #1 check("t3_second_ready", cache_req_ready, 1);
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1; md = '{repl_way: 3'd2, dirty: 1'b1};
        step();
        md_v = 1'b0;
        set_req(e_miss_load, 32'h300, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("t3_hold_slot0", lce_req.addr, 32'h100);
            step();
        end
        #1 check("t3_full", cache_req_ready, 0);
        lce_req_ready = 1'b1;
        #1 check("t3_first_slot0", lce_req.addr, 32'h100);
        step();
        #1 check("t3_second_v", lce_req_v, 1);
        check("t3_second_addr", lce_req.addr, 32'h200);
        check("t3_second_type", lce_req.msg_type, e_lce_req_type_wr);
        check("t3_second_excl", lce_req.non_exclusive, e_lce_req_excl);
        check("t3_second_dirty", lce_req.lru_dirty, 1);
        check("t3_second_way", lce_req.lru_way_id, 2);
        step();
        lce_req_ready = 1'b0;
        #1 check("t3_reqs_drained", lce_req_v, 0);
        check("t3_third_refused", cache_req_ready, 0);
        wakeup_v = 1'b1; event_slot = 1'b1;
        step();
        wakeup_v = 1'b0;
        set_tag_v = 1'b1; data_v = 1'b1; event_slot = 1'b0;
        #1 check("t3_ack_slot1", lce_resp.addr, 32'h200);
        step();
        set_tag_v = 1'b0; data_v = 1'b0;
        #1 check("t3_ack_held_slot1", lce_resp.addr, 32'h200);
        check("t3_still_full", cache_req_ready, 0);
        lce_resp_yumi = 1'b1;
        step();
        #1 check("t3_slot1_freed", slot_v, 2'b01);
        check("t3_third_ready", cache_req_ready, 1);
        check("t3_ack_slot0", lce_resp.addr, 32'h100);
        step();
        lce_resp_yumi = 1'b0;
        cache_req_v = 1'b0;
        #1 check("t3_third_in_slot1", slot_v, 2'b10);
        check("t3_third_addr", slot_addr[63:32], 32'h300);
        check("t3_no_ack", lce_resp_v, 0);
        md_v = 1'b1; md = '0;
        step();
        md_v = 1'b0; lce_req_ready = 1'b1;
        step();
        lce_req_ready = 1'b0;
        wakeup_v = 1'b1; event_slot = 1'b1;
        step();
        wakeup_v = 1'b0; lce_resp_yumi = 1'b1;
        step();
        lce_resp_yumi = 1'b0;
        #1 check("t3_all_free", busy, 0);

        // Block hazard: same block refused, different block accepted
        set_req(e_miss_load, 32'h140, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1; md = '0;
        step();
        md_v = 1'b0;
        set_req(e_miss_load, 32'h15C, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        #1 check("hz_same_block", cache_req_ready, 0);
        set_req(e_miss_store, 32'h180, e_size_8, 64'h0);
        #1 check("hz_other_block", cache_req_ready, 1);
        step();
        cache_req_v = 1'b0;
        md_v = 1'b1;
        step();
        md_v = 1'b0;
        lce_req_ready = 1'b1;
        step();
        step();
        lce_req_ready = 1'b0;
        wakeup_v = 1'b1; event_slot = 1'b0;
        step();
        wakeup_v = 1'b0;
        #1 check("rs_ack_pending", lce_resp_v, 1);

        // Asynchronous reset mid-operation
        #2 reset_n = 1'b0;
        #1 check("rs_resp_v", lce_resp_v, 0);
        check("rs_req_v", lce_req_v, 0);
        check("rs_busy", busy, 0);
        check("rs_slot_v", slot_v, 0);
        #2 reset_n = 1'b1;
        step();
        set_req(e_miss_load, 32'h8000_0040, e_size_8, 64'h0);
        cache_req_v = 1'b1;
        #1 check("rs_ready_after", cache_req_ready, 1);
        step();
        cache_req_v = 1'b0;
        #1 check("rs_slot0", slot_v, 2'b01);
        check("rs_slot0_addr", slot_addr[31:0], 32'h8000_0040);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
